// File: rtl/main_control_fsm.sv
// main_control_fsm
// Multicycle main control FSM for the 16-bit CPU. Decodes IR[15:12] and
// drives the datapath strobes, the 2-bit ALUOp for the ALU control decoder,
// and the request side of the unified memory handshake (mem_ready).
// Optional feature macro: MAIN_CTRL_JUMP_EN (adds the JUMP state and makes
// OP_JMP a legal opcode; when undefined OP_JMP raises illegal_op).
module main_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  // Opcodes (IR[15:12])
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_SHIFT = 4'b0010;
  localparam logic [3:0] OP_LW    = 4'b0100;
  localparam logic [3:0] OP_SW    = 4'b0101;
  localparam logic [3:0] OP_BEQ   = 4'b0110;
  localparam logic [3:0] OP_JMP   = 4'b0111;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_SUBI  = 4'b1010;
  localparam logic [3:0] OP_SLTI  = 4'b1011;

  // State encodings (visible on state_dbg)
  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_MEMADDR = 4'd2;
  localparam logic [3:0] ST_MEMRD   = 4'd3;
  localparam logic [3:0] ST_MEMWB   = 4'd4;
  localparam logic [3:0] ST_MEMWR   = 4'd5;
  localparam logic [3:0] ST_EXEC_R  = 4'd6;
  localparam logic [3:0] ST_RWB     = 4'd7;
  localparam logic [3:0] ST_BRANCH  = 4'd8;
  localparam logic [3:0] ST_EXEC_I  = 4'd9;
  localparam logic [3:0] ST_IWB     = 4'd10;
  localparam logic [3:0] ST_JUMP    = 4'd11;

  // Opcode legality as seen by DECODE; JMP is legal only in the jump build.
  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_RTYPE, OP_SHIFT, OP_LW, OP_SW, OP_BEQ,
      OP_ADDI, OP_SUBI, OP_SLTI: legal = 1'b1;
`ifdef MAIN_CTRL_JUMP_EN
      OP_JMP:                    legal = 1'b1;
`else
      OP_JMP:                    legal = 1'b0;
`endif
      default:                   legal = 1'b0;
    endcase
    return legal;
  endfunction

  logic [3:0] state_r;
  logic [3:0] next_state_s;

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; opcode is only consulted in DECODE and MEMADDR.
  always_comb begin
    next_state_s = ST_FETCH;
    case (state_r)
      ST_FETCH: begin
        if (mem_ready) begin
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                         next_state_s = ST_MEMADDR;
          OP_RTYPE:                             next_state_s = ST_EXEC_R;
          OP_BEQ:                               next_state_s = ST_BRANCH;
          OP_ADDI, OP_SUBI, OP_SLTI, OP_SHIFT:  next_state_s = ST_EXEC_I;
`ifdef MAIN_CTRL_JUMP_EN
          OP_JMP:                               next_state_s = ST_JUMP;
`endif
          default:                              next_state_s = ST_FETCH;
        endcase
      end
      ST_MEMADDR: begin
        if (opcode == OP_LW) begin
          next_state_s = ST_MEMRD;
        end else if (opcode == OP_SW) begin
          next_state_s = ST_MEMWR;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_MEMRD: begin
        if (mem_ready) begin
          next_state_s = ST_MEMWB;
        end else begin
          next_state_s = ST_MEMRD;
        end
      end
      ST_MEMWR: begin
        if (mem_ready) begin
          next_state_s = ST_FETCH;
        end else begin
          next_state_s = ST_MEMWR;
        end
      end
      ST_MEMWB:  next_state_s = ST_FETCH;
      ST_EXEC_R: next_state_s = ST_RWB;
      ST_RWB:    next_state_s = ST_FETCH;
      ST_EXEC_I: next_state_s = ST_IWB;
      ST_IWB:    next_state_s = ST_FETCH;
      ST_BRANCH: next_state_s = ST_FETCH;
`ifdef MAIN_CTRL_JUMP_EN
      ST_JUMP:   next_state_s = ST_FETCH;
`endif
      default:   next_state_s = ST_FETCH;
    endcase
  end

  // Output decode: all strobes low during reset; FETCH IR/PC load and the
  // DECODE illegal-opcode flag depend on inputs in the current cycle.
  always_comb begin
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    illegal_op  = 1'b0;
    state_dbg   = 4'd0;
    if (reset) begin
      state_dbg = 4'd0;
    end else begin
      state_dbg = state_r;
      case (state_r)
        ST_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end else begin
            IRWrite = 1'b0;
            PCWrite = 1'b0;
          end
        end
        ST_DECODE: begin
          ALUSrcB    = 2'b11;
          illegal_op = ~is_legal_op(opcode);
        end
        ST_MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        ST_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        ST_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        ST_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        ST_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        ST_RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        ST_EXEC_I: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b11;
        end
        ST_IWB: begin
          RegWrite = 1'b1;
        end
        ST_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
`ifdef MAIN_CTRL_JUMP_EN
        ST_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
`endif
        default: begin
          state_dbg = state_r;
        end
      endcase
    end
  end

endmodule
